// File: rtl/bank_match_sequencer.sv
// ============================================================================
// Module   : bank_match_sequencer
// Purpose  : Scans NBANK stored words with a one-hot select, compares each one
//            against a captured target and publishes per-bank match bits and
//            an OR flag at the end of every scan.
//            Optional macro MATCH_COUNT_EN adds a saturating 8-bit counter of
//            scans that produced at least one match (output match_cnt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_match_sequencer #(
    parameter int WIDTH = 11,
    parameter int NBANK = 3
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   target,
    input  logic               wr_en,
    input  logic [2:0]         wr_bank,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [NBANK-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic [NBANK-1:0]   match_vec,
    output logic               flag
`ifdef MATCH_COUNT_EN
    ,
    output logic [7:0]         match_cnt
`endif
);

    localparam int IW = (NBANK > 2) ? $clog2(NBANK) : 1;
    localparam logic [IW-1:0] C_LAST_IDX = IW'(NBANK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [WIDTH-1:0]   target_q;
    logic [WIDTH-1:0]   bank_q [NBANK];
    logic [NBANK-1:0]   acc_q;
    logic [NBANK-1:0]   match_vec_q;
    logic               busy_q;
    logic               done_q;
    logic               flag_q;
    logic               hit_d;
    logic               last_d;
`ifdef MATCH_COUNT_EN
    logic [7:0]         cnt_q;
`endif

    // Compare sees the bank value from before this edge, so a same-cycle
    // write to the selected bank only affects later scans.
    assign hit_d  = (bank_q[idx_q] == target_q);
    assign last_d = (idx_q == C_LAST_IDX);

    always_comb begin
        sel = '0;
        if (state_q == S_SCAN) begin
            sel[idx_q] = 1'b1;
        end
    end

    // Out-of-range wr_bank values simply match no bank and are dropped.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        always_ff @(posedge CK) begin
            if (RST) begin
                bank_q[b] <= '0;
            end else if (wr_en && (wr_bank == 3'(b))) begin
                bank_q[b] <= wr_data;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            target_q    <= '0;
            acc_q       <= '0;
            match_vec_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flag_q      <= 1'b0;
`ifdef MATCH_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && en) begin
                        target_q <= target;
                        idx_q    <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (en) begin
                        acc_q[idx_q] <= hit_d;
                        if (last_d) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // en low also holds off the result publication.
                    if (en) begin
                        done_q      <= 1'b1;
                        match_vec_q <= acc_q;
                        flag_q      <= |acc_q;
                        busy_q      <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
`ifdef MATCH_COUNT_EN
                        if ((|acc_q) && (cnt_q != 8'hFF)) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match_vec = match_vec_q;
    assign flag      = flag_q;
`ifdef MATCH_COUNT_EN
    assign match_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_match_sequencer.sv
// ============================================================================
// Module   : tb_bank_match_sequencer
// Purpose  : Self-checking bench for bank_match_sequencer (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_match_sequencer;

    localparam int W = 11;
    localparam int N = 3;

    logic           CK = 1'b0;
    logic           RST = 1'b1;
    logic           en = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   target = '0;
    logic           wr_en = 1'b0;
    logic [2:0]     wr_bank = '0;
    logic [W-1:0]   wr_data = '0;
    logic [N-1:0]   sel;
    logic           busy;
    logic           done;
    logic [N-1:0]   match_vec;
    logic           flag;
`ifdef MATCH_COUNT_EN
    logic [7:0]     match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: bank contents and published results.
    logic [W-1:0]   bank_m [N];
    logic [N-1:0]   mv_m = '0;
    int             cnt_m = 0;

    bank_match_sequencer #(.WIDTH(W), .NBANK(N)) dut (
        .CK        (CK),
        .RST       (RST),
        .en        (en),
        .start     (start),
        .target    (target),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_data   (wr_data),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .match_vec (match_vec),
        .flag      (flag)
`ifdef MATCH_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_bank(input logic [2:0] b, input logic [W-1:0] d);
        wr_en = 1'b1; wr_bank = b; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (int'(b) < N) bank_m[int'(b)] = d;
    endtask

    task automatic clear_model();
        for (int b = 0; b < N; b++) bank_m[b] = '0;
        mv_m = '0;
        cnt_m = 0;
    endtask

    // pmode: 0 = en held high, 1 = two-cycle pause while bank 1 selected,
    // 2 = random pauses. wr_at >= 0 writes wdat into that bank in the very
    // cycle it is being compared.
    task automatic run_scan(input logic [W-1:0] tgt, input int pmode,
                            input int wr_at, input logic [W-1:0] wdat);
        logic [N-1:0] expv;
        int comp, pauses, k, hold;
        for (int b = 0; b < N; b++) expv[b] = (bank_m[b] == tgt);
        target = tgt; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        comp = 0; pauses = 0; k = 0; hold = 0;
        while (done !== 1'b1 && k < 40) begin
            check("sel", sel, (comp < N) ? (32'd1 << comp) : 32'd0);
            start  = 1'($urandom_range(0, 1));
            target = W'($urandom);
            en = 1'b1;
            if (comp < N) begin
                if (pmode == 1 && comp == 1 && hold < 2) begin
                    en = 1'b0; hold++;
                end else if (pmode == 2 && $urandom_range(0, 3) == 0) begin
                    en = 1'b0;
                end
            end
            if (en && comp == wr_at) begin
                wr_en = 1'b1; wr_bank = 3'(wr_at); wr_data = wdat;
            end
            if (!en) pauses++;
            else if (comp < N) comp++;
            tick();
            k++;
            if (wr_en) bank_m[wr_at] = wdat;
            wr_en = 1'b0;
        end
        start = 1'b0; en = 1'b1;
        mv_m = expv;
        if (|expv && cnt_m < 255) cnt_m++;
        check("done_seen", done, 1);
        check("latency", k, N + 1 + pauses);
        check("match_vec", match_vec, mv_m);
        check("flag", flag, |mv_m);
        check("busy_at_done", busy, 0);
`ifdef MATCH_COUNT_EN
        check("match_cnt", match_cnt, cnt_m);
`endif
        tick();
        check("done_pulse_end", done, 0);
        check("match_vec_hold", match_vec, mv_m);
    endtask

    initial begin
        logic [W-1:0] t;
        logic clash;
        clear_model();
        tick(); tick();
        RST = 1'b0;
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match_vec", match_vec, 0);
        check("rst_flag", flag, 0);
`ifdef MATCH_COUNT_EN
        check("rst_match_cnt", match_cnt, 0);
`endif

        // Directed scans on the reference bank pattern.
        write_bank(3'd0, 11'h155);
        write_bank(3'd1, 11'h2AA);
        write_bank(3'd2, 11'h7FF);
        write_bank(3'd5, 11'h2AA);
        run_scan(11'h2AA, 0, -1, '0);
        check("dir_mv_010", match_vec, 3'b010);
        run_scan(11'h000, 0, -1, '0);
        check("dir_mv_000", match_vec, 3'b000);
        run_scan(11'h7FF, 0, -1, '0);
        check("dir_mv_100", match_vec, 3'b100);

        // Pause two cycles while bank 1 is selected.
        run_scan(11'h2AA, 1, -1, '0);
        check("pause_mv", match_vec, 3'b010);

        // Same-cycle write to the bank under compare.
        write_bank(3'd1, 11'h155);
        run_scan(11'h2AA, 0, 1, 11'h2AA);
        check("wr_same_cycle_mv1", match_vec[1], 0);
        run_scan(11'h2AA, 0, -1, '0);
        check("rescan_mv1", match_vec[1], 1);

        // Reset in the middle of a scan.
        target = 11'h2AA; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_sel", sel, 3'b010);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        clear_model();
        check("mid_rst_sel", sel, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_match_vec", match_vec, 0);
        check("mid_rst_flag", flag, 0);
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_no_done", done, 0);
            tick();
        end
        run_scan(11'h000, 0, -1, '0);
        check("banks_cleared_mv", match_vec, 3'b111);

        // Random banks, targets and pauses.
        for (int r = 0; r < 25; r++) begin
            for (int w = 0; w < 3; w++) write_bank(3'($urandom_range(0, 7)), W'($urandom));
            if ($urandom_range(0, 1) == 1) t = bank_m[$urandom_range(0, N - 1)];
            else t = W'($urandom);
            run_scan(t, 2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                     W'($urandom));
        end

`ifdef MATCH_COUNT_EN
        for (int r = 0; r < 300; r++) run_scan(bank_m[0], 0, -1, '0);
        check("cnt_saturated", match_cnt, 255);
        t = bank_m[0];
        clash = 1'b1;
        while (clash) begin
            t = t + 1'b1;
            clash = 1'b0;
            for (int b = 0; b < N; b++) if (bank_m[b] == t) clash = 1'b1;
        end
        run_scan(t, 0, -1, '0);
        check("cnt_hold_255", match_cnt, 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
